// File: rtl/alu_32_if.sv
// Operand/result bundle for alu_32: the datapath side drives operands and
// opcode, the ALU side returns the registered result and status flags.
interface alu_32_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] result;
    logic        c;
    logic        v;
    logic        z;
    logic        n;

    modport master (
        output a, b, op,
        input  result, c, v, z, n
    );

    modport slave (
        input  a, b, op,
        output result, c, v, z, n
    );
endinterface

// File: rtl/alu_32.sv
// 32-bit ALU with one registered output stage (result plus c/v/z/n flags).
// Optional macro ALU32_MUL_EN maps op 1101 to the low 32 bits of a*b.
module alu_32 (
    input  logic      clk,
    input  logic      reset_n,
    alu_32_if.slave   bus
);

    localparam int DATA_W = 32;

    logic [DATA_W-1:0]        res_p0;
    logic                     c_p0;
    logic                     v_p0;
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [4:0]               sh;
    logic [DATA_W+1:0]        addsub_p0;

    logic [DATA_W-1:0]        result_p1;
    logic                     c_p1;
    logic                     v_p1;
    logic                     z_p1;
    logic                     n_p1;

    // Returns {v, c, sum}; subtraction is x + ~y + 1 so c reads as no-borrow.
    function automatic logic [DATA_W+1:0] addsub(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y,
        input logic              sub
    );
        logic [DATA_W-1:0] y_eff;
        logic [DATA_W:0]   sum;
        logic              ovf;
        y_eff = sub ? ~y : y;
        sum   = {1'b0, x} + {1'b0, y_eff} + {{DATA_W{1'b0}}, sub};
        ovf   = (x[DATA_W-1] == y_eff[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
        return {ovf, sum};
    endfunction

    assign a_s = bus.a;
    assign b_s = bus.b;
    assign sh  = bus.b[4:0];

    // Stage p0: combinational operation select
    always_comb begin
        res_p0    = '0;
        c_p0      = 1'b0;
        v_p0      = 1'b0;
        addsub_p0 = addsub(bus.a, bus.b, bus.op == 4'b1100);
        unique case (bus.op)
            4'b0000: res_p0 = ~bus.a;
            4'b0001: res_p0 = ~bus.b;
            4'b0010: res_p0 = bus.a & bus.b;
            4'b0011: res_p0 = bus.a | bus.b;
            4'b0100: res_p0 = bus.a ^ bus.b;
            4'b0101: res_p0 = ~(bus.a ^ bus.b);
            4'b0110: res_p0 = (a_s < b_s) ? 32'd1 : 32'd0;
            4'b0111: res_p0 = (a_s > b_s) ? 32'd1 : 32'd0;
            4'b1000: res_p0 = bus.a << sh;
            4'b1001: res_p0 = bus.a >> sh;
            4'b1010: res_p0 = $unsigned(a_s >>> sh);
            4'b1011, 4'b1100: begin
                res_p0 = addsub_p0[DATA_W-1:0];
                c_p0   = addsub_p0[DATA_W];
                v_p0   = addsub_p0[DATA_W+1];
            end
`ifdef ALU32_MUL_EN
            4'b1101: res_p0 = bus.a * bus.b;
`else
            4'b1101: res_p0 = '0;
`endif
            default: res_p0 = '0;
        endcase
    end

    // Stage p1: registered result and flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_p1 <= '0;
            c_p1      <= 1'b0;
            v_p1      <= 1'b0;
            z_p1      <= 1'b0;
            n_p1      <= 1'b0;
        end else begin
            result_p1 <= res_p0;
            c_p1      <= c_p0;
            v_p1      <= v_p0;
            z_p1      <= (res_p0 == '0);
            n_p1      <= res_p0[DATA_W-1];
        end
    end

    assign bus.result = result_p1;
    assign bus.c      = c_p1;
    assign bus.v      = v_p1;
    assign bus.z      = z_p1;
    assign bus.n      = n_p1;

endmodule

// File: tb/tb_alu_32.sv
// Directed bench for alu_32: expected values queued at drive time, popped
// and compared one edge later.
module tb_alu_32;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    typedef struct {
        string       tag;
        logic [31:0] result;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    exp_t sb[$];

    alu_32_if bus ();

    alu_32 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic compare_one();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".result"}, bus.result, e.result);
        chk({e.tag, ".c"}, {31'd0, bus.c}, {31'd0, e.c});
        chk({e.tag, ".v"}, {31'd0, bus.v}, {31'd0, e.v});
        chk({e.tag, ".z"}, {31'd0, bus.z}, {31'd0, e.z});
        chk({e.tag, ".n"}, {31'd0, bus.n}, {31'd0, e.n});
    endtask

    task automatic step(input string tag, input logic rn, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] r, input logic c, input logic v,
                        input logic z, input logic n);
        exp_t e;
        @(negedge clk);
        reset_n = rn;
        bus.a   = a;
        bus.b   = b;
        bus.op  = op;
        e.tag = tag; e.result = r; e.c = c; e.v = v; e.z = z; e.n = n;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_one();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.a   = 32'h0000_000A;
        bus.b   = 32'h0000_0003;
        bus.op  = 4'b1011;

        // Reset held two edges with an add pending
        step("rst0", 1'b0, 32'hA, 32'h3, 4'b1011, 32'h0, 0, 0, 0, 0);
        step("rst1", 1'b0, 32'hA, 32'h3, 4'b1011, 32'h0, 0, 0, 0, 0);

        // Release: output must stay 0 until the next edge
        @(negedge clk);
        reset_n = 1'b1;
        begin
            exp_t e;
            e.tag = "release"; e.result = 32'hD; e.c = 0; e.v = 0; e.z = 0; e.n = 0;
            sb.push_back(e);
        end
        #1;
        chk("pre_release.result", bus.result, 32'h0);
        @(posedge clk);
        #1;
        compare_one();

        // Logic ops
        step("not_a",  1'b1, 32'hA, 32'h3, 4'b0000, 32'hFFFF_FFF5, 0, 0, 0, 1);
        step("not_b",  1'b1, 32'hA, 32'h3, 4'b0001, 32'hFFFF_FFFC, 0, 0, 0, 1);
        step("and",    1'b1, 32'hA, 32'h3, 4'b0010, 32'h2, 0, 0, 0, 0);
        step("or",     1'b1, 32'hA, 32'h3, 4'b0011, 32'hB, 0, 0, 0, 0);
        step("xor",    1'b1, 32'hA, 32'h3, 4'b0100, 32'h9, 0, 0, 0, 0);
        step("xnor",   1'b1, 32'hA, 32'h3, 4'b0101, 32'hFFFF_FFF6, 0, 0, 0, 1);

        // Compare and shift
        step("slt",    1'b1, 32'hA, 32'h3, 4'b0110, 32'h0, 0, 0, 1, 0);
        step("sgt",    1'b1, 32'hA, 32'h3, 4'b0111, 32'h1, 0, 0, 0, 0);
        step("lsl",    1'b1, 32'hA, 32'h3, 4'b1000, 32'h50, 0, 0, 0, 0);
        step("lsr",    1'b1, 32'hA, 32'h3, 4'b1001, 32'h1, 0, 0, 0, 0);
        step("slt_neg",1'b1, 32'h8000_0000, 32'h4, 4'b0110, 32'h1, 0, 0, 0, 0);
        step("asr_neg",1'b1, 32'h8000_0000, 32'h4, 4'b1010, 32'hF800_0000, 0, 0, 0, 1);
        step("lsr_neg",1'b1, 32'h8000_0000, 32'h4, 4'b1001, 32'h0800_0000, 0, 0, 0, 0);
        step("lsl_sh0",1'b1, 32'h1234_5678, 32'h0000_0020, 4'b1000, 32'h1234_5678, 0, 0, 0, 0);
        step("lsr_hib",1'b1, 32'h0000_0100, 32'hFFFF_FFE1, 4'b1001, 32'h0000_0080, 0, 0, 0, 0);

        // Arithmetic
        step("add",    1'b1, 32'hA, 32'h3, 4'b1011, 32'hD, 0, 0, 0, 0);
        step("sub",    1'b1, 32'hA, 32'h3, 4'b1100, 32'h7, 1, 0, 0, 0);
        step("sub_brw",1'b1, 32'h3, 32'hA, 4'b1100, 32'hFFFF_FFF9, 0, 0, 0, 1);
        step("add_wrap",1'b1, 32'hFFFF_FFFF, 32'h1, 4'b1011, 32'h0, 1, 0, 1, 0);
        step("add_ovf",1'b1, 32'h7FFF_FFFF, 32'h1, 4'b1011, 32'h8000_0000, 0, 1, 0, 1);
        step("sub_ovf",1'b1, 32'h8000_0000, 32'h1, 4'b1100, 32'h7FFF_FFFF, 1, 1, 0, 0);

        // Reserved and optional opcode
        step("rsv_e",  1'b1, 32'hA, 32'h3, 4'b1110, 32'h0, 0, 0, 1, 0);
        step("rsv_f",  1'b1, 32'hA, 32'h3, 4'b1111, 32'h0, 0, 0, 1, 0);
`ifdef ALU32_MUL_EN
        step("mul",    1'b1, 32'hA, 32'h3, 4'b1101, 32'h1E, 0, 0, 0, 0);
`else
        step("rsv_d",  1'b1, 32'hA, 32'h3, 4'b1101, 32'h0, 0, 0, 1, 0);
`endif

        // Reset priority over a live add
        step("rst_mid",1'b0, 32'hA, 32'h3, 4'b1011, 32'h0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_32.md
Name: alu_32

Overview:
- 32-bit combinational-operand ALU with a registered result. Sits in the datapath after operand selection.
- A 4-bit opcode selects one of 13 logic, compare, shift or arithmetic operations; unused opcodes return zero.
- Result and status flags are captured on the rising clock edge, so the block has one cycle of latency.

Parameters:
- None. Width is fixed at 32 bits.

Ports:
- clk      input   1   rising-edge clock
- reset_n  input   1   synchronous active-low reset
- a        input   32  operand A
- b        input   32  operand B (shift amount is b[4:0])
- op       input   4   operation select
- result   output  32  registered operation result
- c        output  1   registered carry / no-borrow (add/sub only, else 0)
- v        output  1   registered signed overflow (add/sub only, else 0)
- z        output  1   registered: result == 0
- n        output  1   registered: result[31]

Behaviour:
- Reset: reset_n sampled low at a clk rising edge sets result, c, v, z and n to 0. Reset has priority over any operation.
- Latency: inputs are sampled at edge k; outputs are valid after edge k. There is no handshake, and a new op is accepted every cycle.
- Opcode map:
  - 0000: ~a
  - 0001: ~b
  - 0010: a & b
  - 0011: a | b
  - 0100: a ^ b
  - 0101: ~(a ^ b)
  - 0110: set-less-than, signed; result = 1 if $signed(a) < $signed(b), else 0
  - 0111: set-greater-than, signed; result = 1 if $signed(a) > $signed(b), else 0
  - 1000: LSL, a << b[4:0], zero fill
  - 1001: LSR, a >> b[4:0], zero fill
  - 1010: ASR, a >>> b[4:0], sign fill from a[31]
  - 1011: a + b
  - 1100: a - b, computed as a + ~b + 1
  - 1101, 1110, 1111: result = 0 (reserved); 1101 changes when the optional feature is enabled
- Shift rules:
  - b[31:5] is ignored.
  - A shift amount of 0 passes a through unchanged.
- Add/sub flags:
  - c = carry out of bit 31. For sub, c = 1 means no borrow (a >= b unsigned).
  - v = 1 when both operands, after b inversion for sub, have equal sign and the sum sign differs.
- Flags for all other ops:
  - c = 0 and v = 0.
  - z and n always follow the registered result.
- Wrap-around: add and sub are modulo 2^32. 0xFFFFFFFF + 1 gives result 0, c = 1, z = 1.
- X/unknown op is not required to be handled; the default branch drives result 0.

Optional Feature:
- Macro: ALU32_MUL_EN.
- Defined: op 1101 returns the low 32 bits of a*b (unsigned). c = 0, v = 0, z and n follow the result.
- Not defined: op 1101 behaves as reserved (result 0). No multiplier logic is synthesized.

Test Plan:
- Logic ops, a=0x0000000A, b=0x00000003, one op per cycle:
  - 0000 -> 0xFFFFFFF5
  - 0001 -> 0xFFFFFFFC
  - 0010 -> 0x2
  - 0011 -> 0xB
  - 0100 -> 0x9
  - 0101 -> 0xFFFFFFF6
- Compare/shift with the same operands:
  - 0110 -> 0
  - 0111 -> 1
  - 1000 -> 0x50
  - 1001 -> 0x1
- Signed compare and ASR, a=0x80000000, b=4:
  - 0110 -> 1
  - 1010 -> 0xF8000000, n = 1
  - 1001 -> 0x08000000
- Arithmetic:
  - a=0xA, b=3, op 1011 -> 0xD
  - a=0xA, b=3, op 1100 -> 0x7, c = 1
  - a=0xFFFFFFFF, b=1, op 1011 -> 0, c = 1, z = 1
  - a=0x7FFFFFFF, b=1, op 1011 -> 0x80000000, v = 1, n = 1
- Reserved opcodes and feature:
  - op 1110 and 1111 -> result 0, z = 1.
  - op 1101 with a=0xA, b=3 -> 0x1E if ALU32_MUL_EN is defined, else 0.
- Reset and latency:
  - Hold reset_n = 0 for 2 edges with op=1011 active -> all outputs 0.
  - Release reset_n; result is 0xD after the first edge following release, not before.
